// File: rtl/width_12to8.sv
// width_12to8: 12-bit word stream in, 8-bit byte stream out.
// Every two words become three bytes, MSB nibble first. A 6-nibble buffer
// (slot 0 = head, held in buf_q[23:20]) absorbs rate mismatch and backpressure.
// Optional macro W12TO8_FLUSH_EN adds a 'flush' input that pads a lone
// trailing nibble with 4'h0 so it can leave as a byte.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. ready_in and valid_out are decoded from registered state only
// (plus rst), so there is no combinational path from valid_in/ready_out to
// any output.
module width_12to8 (
`ifdef W12TO8_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [11:0] data_in,
  output logic        ready_in,
  output logic        valid_out,
  output logic [7:0]  data_out,
  input  logic        ready_out
);

  // Slots beyond nib_cnt_q are always kept at zero, so a flush can simply
  // extend the count over an already-zero slot.
  logic [23:0] buf_q, buf_d, buf_pop;
  logic [2:0]  nib_cnt_q, nib_cnt_d, cnt_pop;
  logic        push, pop;

  assign ready_in  = (nib_cnt_q <= 3'd3) && !rst;
  assign valid_out = (nib_cnt_q >= 3'd2) && !rst;
  assign data_out  = valid_out ? buf_q[23:16] : 8'h00;

  assign push = valid_in && ready_in;
  assign pop  = valid_out && ready_out;

  // Next buffer state: pop shifts the head byte out first, then a push
  // appends its three nibbles right after the surviving ones.
  always_comb begin
    buf_pop   = pop ? {buf_q[15:0], 8'h00} : buf_q;
    cnt_pop   = pop ? (nib_cnt_q - 3'd2) : nib_cnt_q;
    buf_d     = buf_pop;
    nib_cnt_d = cnt_pop;
    if (push) begin
      nib_cnt_d = cnt_pop + 3'd3;
      case (cnt_pop)
        3'd0:    buf_d[23:12] = data_in;
        3'd1:    buf_d[19:8]  = data_in;
        3'd2:    buf_d[15:4]  = data_in;
        default: buf_d[11:0]  = data_in;
      endcase
    end
`ifdef W12TO8_FLUSH_EN
    else if (flush && (nib_cnt_q == 3'd1)) begin
      nib_cnt_d = 3'd2;
    end
`endif
  end

  // State register with synchronous reset that drops all buffered nibbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= 24'h0;
      nib_cnt_q <= 3'd0;
    end else begin
      buf_q     <= buf_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end

endmodule

// File: tb/tb_width_12to8.sv
// Testbench for width_12to8: directed scenarios plus randomized traffic,
// checked against a nibble-queue reference model.
module tb_width_12to8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [11:0] data_in;
  logic        ready_in;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        ready_out;
  logic        flush_s;

  int checks = 0;
  int errors = 0;

  logic [3:0] nq[$];     // reference model: buffered nibbles, head first
  logic [7:0] exp_q[$];  // expected popped bytes for directed tests
  logic       did_push, did_pop;

  always #5 clk = ~clk;

  width_12to8 dut (
`ifdef W12TO8_FLUSH_EN
    .flush     (flush_s),
`endif
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_out (ready_out)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  task automatic step(input logic r, input logic vi, input logic [11:0] di,
                      input logic ro, input logic fl);
    logic       e_rdy, e_vld;
    logic [7:0] e_dat;
    rst = r; valid_in = vi; data_in = di; ready_out = ro; flush_s = fl;
    #1;
    e_rdy = (nq.size() <= 3) && !r;
    e_vld = (nq.size() >= 2) && !r;
    e_dat = 8'h00;
    if (e_vld) e_dat = {nq[0], nq[1]};
    chk("ready_in", {15'd0, ready_in}, {15'd0, e_rdy});
    chk("valid_out", {15'd0, valid_out}, {15'd0, e_vld});
    chk("data_out", {8'd0, data_out}, {8'd0, e_dat});
    did_push = vi && e_rdy;
    did_pop  = e_vld && ro;
    if (did_pop && exp_q.size() > 0) chk("byte", {8'd0, data_out}, {8'd0, exp_q.pop_front()});
    if (r) begin
      nq.delete();
    end else begin
      if (did_pop) begin
        void'(nq.pop_front());
        void'(nq.pop_front());
      end
      if (did_push) begin
        nq.push_back(di[11:8]);
        nq.push_back(di[7:4]);
        nq.push_back(di[3:0]);
      end
`ifdef W12TO8_FLUSH_EN
      else if (fl && nq.size() == 1) nq.push_back(4'h0);
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer a word until accepted (bounded), with the given ready_out.
  task automatic send(input logic [11:0] w, input logic ro);
    int n = 0;
    do begin
      step(1'b0, 1'b1, w, ro, 1'b0);
      n++;
    end while (!did_push && n < 20);
    if (!did_push) chk("send_timeout", 16'd0, 16'd1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 12'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [11:0] w;
    logic        have;
    int          sent;
    int          cyc;
    rst = 1'b1; valid_in = 1'b0; data_in = 12'h0; ready_out = 1'b0; flush_s = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset mid-stream discards the buffered word.
    step(1'b0, 1'b1, 12'hABC, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
    exp_q.push_back(8'h12);
    step(1'b0, 1'b1, 12'h123, 1'b1, 1'b0);
    drain(2);
    do_reset();

    // Streaming with ready_out high.
    exp_q = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
    send(12'hABC, 1'b1);
    send(12'hDEF, 1'b1);
    send(12'h123, 1'b1);
    send(12'h456, 1'b1);
    drain(4);
    chk("stream_done", exp_q.size(), 16'd0);
    do_reset();

    // Backpressure: fill to 6 nibbles, then release.
    send(12'h111, 1'b0);
    send(12'h222, 1'b0);
    step(1'b0, 1'b1, 12'h333, 1'b0, 1'b0);
    chk("full_no_push", {15'd0, did_push}, 16'd0);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    exp_q = '{8'h11, 8'h12, 8'h22};
    drain(4);
    chk("bp_done", exp_q.size(), 16'd0);
    do_reset();

    // Simultaneous push and pop at three nibbles.
    send(12'hABC, 1'b0);
    exp_q = '{8'hAB, 8'hC7, 8'h89};
    step(1'b0, 1'b1, 12'h789, 1'b1, 1'b0);
    chk("sim_push", {15'd0, did_push}, 16'd1);
    chk("sim_pop", {15'd0, did_pop}, 16'd1);
    drain(3);
    chk("sim_done", exp_q.size(), 16'd0);
    do_reset();

    // Trailing single nibble: flushed as C0, or left pending.
    send(12'hABC, 1'b0);
    exp_q.push_back(8'hAB);
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
`ifdef W12TO8_FLUSH_EN
    exp_q.push_back(8'hC0);
    step(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    drain(2);
`else
    step(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    drain(2);
`endif
    chk("flush_done", exp_q.size(), 16'd0);
    do_reset();

    // Random traffic, 1000 words; the upstream holds a word until accepted.
    sent = 0; have = 1'b0; w = 12'h0; cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      if (!have) begin
        w = 12'($urandom_range(0, 4095));
        have = 1'b1;
      end
      step(1'b0, ($urandom_range(0, 9) < 7), w, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 3) == 0));
      if (did_push) begin
        have = 1'b0;
        sent++;
      end
      cyc++;
    end
    chk("random_sent", sent[15:0], 16'd1000);
    drain(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
